// File: rtl/spi_cmd_rx_if.sv
// SPI command receiver bus: raw SPI pins in, decoded byte stream out.
// The receiver holds the slave modport; whoever drives the SPI pins and
// consumes the bytes holds the master modport.
interface spi_cmd_rx_if #(
    parameter int CNT_W = 8
);
    // Raw asynchronous SPI pins.
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    // Byte stream and frame status, synchronous to clk.
    // Handshake: byte_ready is a one-cycle strobe with no back-pressure;
    // command_byte is valid on that cycle and held until the next strobe.
    logic [7:0]       command_byte;
    logic             byte_ready;
    logic             frame_active;
    logic             frame_error;
    logic [CNT_W-1:0] byte_count;
    // Receiver FSM state (0 = IDLE, 1 = SHIFT) for checkers.
    logic             dbg_state;

    modport slave (
        input  sclk, cs_n, mosi,
        output command_byte, byte_ready, frame_active, frame_error,
               byte_count, dbg_state
    );

    modport master (
        output sclk, cs_n, mosi,
        input  command_byte, byte_ready, frame_active, frame_error,
               byte_count, dbg_state
    );
endinterface

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) command byte receiver running
// entirely in the clk domain. SCLK/CS/MOSI are oversampled through equal
// depth synchronisers; completed bytes are delivered with a one-cycle
// byte_ready strobe, plus frame tracking and aborted-byte reporting.
module spi_cmd_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_cmd_rx_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchroniser chains; index SYNC_STAGES-1 is the synchronised output.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    // Marks which synchroniser stages hold real samples rather than the
    // reset preset, so a preset cs_n=1 is never mistaken for a real high.
    logic [SYNC_STAGES-1:0] r_vld_sync;
    logic                   r_sclk_d;
    // Set once a genuine cs_n high has been seen; a frame may only start
    // after that, so releasing reset with cs_n low does not open a frame.
    logic                   r_armed;

    logic                   w_s_sclk;
    logic                   w_s_cs_n;
    logic                   w_s_mosi;
    logic                   w_rise;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_frame_start;
    logic                   w_sample;
    logic                   w_last_bit;
    logic                   w_frame_end;
    logic                   w_abort;

    logic [6:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_command_byte;
    logic                   r_byte_ready;
    logic                   r_frame_error;
    logic [CNT_W-1:0]       r_byte_count;

    assign w_s_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_s_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_s_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   = w_s_sclk & ~r_sclk_d;

    // Input synchronisers, SCLK edge-detect flop and frame arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_vld_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_vld_sync  <= {r_vld_sync[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= w_s_sclk;
            r_armed     <= r_armed | (r_vld_sync[SYNC_STAGES-1] & w_s_cs_n);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: a frame opens on an armed cs_n low and closes on cs_n high.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_armed && !w_s_cs_n) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_s_cs_n)             w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: per-cycle datapath controls decoded from state and events.
    always_comb begin
        w_frame_start = 1'b0;
        w_sample      = 1'b0;
        w_last_bit    = 1'b0;
        w_frame_end   = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_frame_start = r_armed & ~w_s_cs_n;
            end
            ST_SHIFT: begin
                w_sample    = w_rise;
                // A completing 8th bit wins over a simultaneous CS release.
                w_last_bit  = w_rise & (r_bit_cnt == 3'd7);
                w_frame_end = w_s_cs_n;
                w_abort     = w_s_cs_n & ((r_bit_cnt != 3'd0) | w_rise) & ~w_last_bit;
            end
            default: ;
        endcase
    end

    // Shift register, bit/byte counters and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_command_byte <= '0;
            r_byte_ready   <= 1'b0;
            r_frame_error  <= 1'b0;
            r_byte_count   <= '0;
        end else begin
            r_byte_ready  <= w_last_bit;
            r_frame_error <= w_abort;
            if (w_frame_start) begin
                r_byte_count <= '0;
                r_bit_cnt    <= '0;
                r_shift      <= '0;
            end else if (w_last_bit) begin
                r_command_byte <= {r_shift, w_s_mosi};
                r_bit_cnt      <= '0;
                r_shift        <= '0;
                if (r_byte_count != {CNT_W{1'b1}}) begin
                    r_byte_count <= r_byte_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (w_frame_end) begin
                // Partial byte is discarded; byte_count stays readable.
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_sample) begin
                r_shift   <= {r_shift[5:0], w_s_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    assign bus.command_byte = r_command_byte;
    assign bus.byte_ready   = r_byte_ready;
    assign bus.frame_active = (r_state == ST_SHIFT);
    assign bus.frame_error  = r_frame_error;
    assign bus.byte_count   = r_byte_count;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Self-checking bench for spi_cmd_rx: drives SPI frames at SCLK = clk/8,
// scoreboards every byte_ready against the bytes sent, and checks frame
// counts, error pulses and reset behaviour against a frame-level model.
module tb_spi_cmd_rx;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int HALF        = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_cmd_rx_if #(.CNT_W(CNT_W)) bus ();

    spi_cmd_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state and reference model
    int         n_checks   = 0;
    int         n_errors   = 0;
    logic [7:0] exp_q[$];
    int         exp_rdy    = 0;
    int         exp_err    = 0;
    int         n_rdy      = 0;
    int         n_err      = 0;
    int         frame_bytes = 0;
    logic [7:0] last_byte  = 8'h00;
    logic       prev_rdy   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: every strobe must match the next sent byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_ready) begin
                n_rdy++;
                check("rdy_back_to_back", {31'd0, prev_rdy}, 32'd0);
                if (exp_q.size() == 0) check("unexpected_rdy", {31'd0, bus.byte_ready}, 32'd0);
                else                   check("command_byte", {24'd0, bus.command_byte}, {24'd0, exp_q.pop_front()});
            end
            if (bus.frame_error) n_err++;
            prev_rdy = bus.byte_ready;
        end else begin
            prev_rdy = 1'b0;
        end
    end

    // Driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.mosi = b;
        wait_clk(HALF);
        bus.sclk = 1'b1;
        wait_clk(HALF);
        bus.sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        exp_q.push_back(v);
        exp_rdy++;
        frame_bytes++;
        last_byte = v;
        send_bits(v, 8);
    endtask

    task automatic cs_low();
        bus.cs_n    = 1'b0;
        frame_bytes = 0;
        wait_clk(HALF);
        @(negedge clk);
        check("frame_active_on", {31'd0, bus.frame_active}, 32'd1);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        bus.cs_n = 1'b1;
        wait_clk(HALF + 4);
    endtask

    // Last bit's rising SCLK edge coincides with cs_n release.
    task automatic send_byte_cs_end(input logic [7:0] v);
        exp_q.push_back(v);
        exp_rdy++;
        frame_bytes++;
        last_byte = v;
        send_bits(v, 7);
        bus.mosi = v[0];
        wait_clk(HALF);
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        wait_clk(HALF);
        bus.sclk = 1'b0;
        wait_clk(HALF + 4);
    endtask

    task automatic frame_check(input string tag);
        int exp_cnt;
        exp_cnt = (frame_bytes > CNT_MAX) ? CNT_MAX : frame_bytes;
        @(negedge clk);
        check({tag, "_byte_count"}, 32'(bus.byte_count), 32'(exp_cnt));
        check({tag, "_rdy_total"}, 32'(n_rdy), 32'(exp_rdy));
        check({tag, "_err_total"}, 32'(n_err), 32'(exp_err));
        check({tag, "_frame_active"}, {31'd0, bus.frame_active}, 32'd0);
        check({tag, "_cmd_hold"}, {24'd0, bus.command_byte}, {24'd0, last_byte});
    endtask

    // Stimulus
    initial begin
        int nb;
        int pb;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        rst_n    = 1'b0;
        wait_clk(3);
        @(negedge clk);
        check("rst_command_byte", {24'd0, bus.command_byte}, 32'd0);
        check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_frame_active", {31'd0, bus.frame_active}, 32'd0);
        check("rst_frame_error", {31'd0, bus.frame_error}, 32'd0);
        check("rst_byte_count", 32'(bus.byte_count), 32'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // Single byte
        cs_low();
        send_byte(8'hA5);
        cs_high();
        frame_check("single");

        // Three bytes back-to-back
        cs_low();
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'hFF);
        cs_high();
        frame_check("three");

        // Aborted byte, then a fresh frame
        cs_low();
        send_bits(8'h3C, 5);
        exp_err++;
        cs_high();
        frame_check("partial");
        cs_low();
        send_byte(8'h55);
        cs_high();
        frame_check("after_partial");

        // Saturating byte counter
        cs_low();
        for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)));
        cs_high();
        frame_check("saturate");

        // Reset in the middle of bit 4
        cs_low();
        send_bits(8'hA0, 4);
        bus.mosi = 1'b1;
        wait_clk(2);
        bus.sclk = 1'b1;
        wait_clk(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_command_byte", {24'd0, bus.command_byte}, 32'd0);
        check("midrst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("midrst_frame_active", {31'd0, bus.frame_active}, 32'd0);
        check("midrst_frame_error", {31'd0, bus.frame_error}, 32'd0);
        check("midrst_byte_count", 32'(bus.byte_count), 32'd0);
        last_byte   = 8'h00;
        frame_bytes = 0;
        wait_clk(3);
        bus.sclk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // cs_n still low: these bits must not assemble a byte.
        send_bits(8'hFF, 8);
        wait_clk(HALF + 4);
        frame_check("post_rst_unarmed");
        cs_high();
        cs_low();
        send_byte(8'hC3);
        cs_high();
        frame_check("post_rst_frame");

        // SCLK activity with cs_n high is ignored
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        wait_clk(HALF + 4);
        frame_check("idle_toggle");

        // 8th rise coincides with cs_n release
        cs_low();
        send_byte_cs_end(8'h96);
        frame_check("coincide");

        // Randomised frames with optional trailing partial byte
        for (int f = 0; f < 6; f++) begin
            cs_low();
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                pb = $urandom_range(1, 7);
                send_bits(8'($urandom_range(0, 255)), pb);
                exp_err++;
            end
            cs_high();
            frame_check("random");
        end

        // Final report
        wait_clk(10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
